// File: rtl/pix_pair_streamer_pkg.sv
// Shared video definitions: timing defaults, streamer FSM encoding
// and RGB565 field layout used by the pairing and threshold blocks.
package pix_pair_streamer_pkg;

  localparam int H_ACT_DEF      = 640;
  localparam int V_ACT_DEF      = 480;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int PIX_W          = 16;

  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic rgb565_t unpack565(input logic [PIX_W-1:0] p);
    rgb565_t c;
    c.r = p[R_HI:R_LO];
    c.g = p[G_HI:G_LO];
    c.b = p[B_HI:B_LO];
    return c;
  endfunction

endpackage

// File: rtl/pix_pair_streamer_fifo.sv
// First-word-fall-through FIFO with synchronous flush; a push in the
// flush cycle survives as the sole entry.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];
  assign wr_en   = flush ? push : do_push;
  assign wr_addr = flush ? '0 : wptr;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= push ? AW'(1) : '0;
      cnt  <= push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pix_pair_streamer.sv
// Aligns a DVI and a CCD pixel stream from their frame starts and
// emits them as coordinate-tagged RGB565 pairs.
module pix_pair_streamer
  import pix_pair_streamer_pkg::*;
#(
  parameter int H_ACT      = H_ACT_DEF,
  parameter int V_ACT      = V_ACT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk_25,
  input  logic             reset,
  input  logic             dvi_valid_i,
  input  logic             dvi_sof_i,
  input  logic [PIX_W-1:0] dvi_pix_i,
  input  logic             ccd_valid_i,
  input  logic             ccd_sof_i,
  input  logic [PIX_W-1:0] ccd_pix_i,
  output logic             valid_o,
  output logic [9:0]       syncX_o,
  output logic [9:0]       syncY_o,
  output logic [4:0]       DVI_R_o,
  output logic [5:0]       DVI_G_o,
  output logic [4:0]       DVI_B_o,
  output logic [4:0]       CCD_R_o,
  output logic [5:0]       CCD_G_o,
  output logic [4:0]       CCD_B_o,
  output logic             frame_done_o,
  output logic             overflow_o
);

  localparam logic [9:0] X_LAST = 10'(H_ACT - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACT - 1);

  state_e           state_q;
  state_e           state_d;
  logic             dvi_armed_q;
  logic             dvi_armed_n;
  logic             ccd_armed_q;
  logic             ccd_armed_n;
  logic [9:0]       x_q;
  logic [9:0]       x_n;
  logic [9:0]       y_q;
  logic [9:0]       y_n;

  logic             dvi_sof;
  logic             ccd_sof;
  logic             dvi_take;
  logic             ccd_take;
  logic             resync;
  logic             pop;
  logic             frame_end;
  logic             ovf_evt;
  logic             restart;
  logic             flush;
  logic             dvi_push;
  logic             ccd_push;
  logic             dvi_full;
  logic             ccd_full;
  logic             dvi_empty;
  logic             ccd_empty;
  logic [PIX_W-1:0] dvi_head;
  logic [PIX_W-1:0] ccd_head;
  rgb565_t          dvi_rgb;
  rgb565_t          ccd_rgb;

  always_comb begin
    dvi_sof   = dvi_valid_i && dvi_sof_i;
    ccd_sof   = ccd_valid_i && ccd_sof_i;
    dvi_take  = dvi_valid_i && (dvi_armed_q || dvi_sof_i);
    ccd_take  = ccd_valid_i && (ccd_armed_q || ccd_sof_i);
    resync    = (dvi_sof && dvi_armed_q) || (ccd_sof && ccd_armed_q);
    pop       = (state_q == RUN) && !dvi_empty && !ccd_empty;
    frame_end = pop && (x_q == X_LAST) && (y_q == Y_LAST);
    // a fresh sof lands in an empty FIFO, so only data pixels overflow
    ovf_evt   = !resync &&
                ((dvi_take && !dvi_sof && dvi_full && !pop) ||
                 (ccd_take && !ccd_sof && ccd_full && !pop));
    restart   = resync || frame_end;
    flush     = ovf_evt || restart;
    dvi_push  = !ovf_evt && (restart ? dvi_sof : dvi_take);
    ccd_push  = !ovf_evt && (restart ? ccd_sof : ccd_take);
  end

  always_comb begin
    dvi_armed_n = dvi_armed_q;
    ccd_armed_n = ccd_armed_q;
    if (ovf_evt) begin
      dvi_armed_n = 1'b0;
      ccd_armed_n = 1'b0;
    end else begin
      if (dvi_sof) begin
        dvi_armed_n = 1'b1;
      end else if (restart) begin
        dvi_armed_n = 1'b0;
      end
      if (ccd_sof) begin
        ccd_armed_n = 1'b1;
      end else if (restart) begin
        ccd_armed_n = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_n     = x_q;
    y_n     = y_q;
    if (flush) begin
      state_d = WAIT_SOF;
      x_n     = '0;
      y_n     = '0;
    end else begin
      unique case (state_q)
        WAIT_SOF: begin
          if (dvi_armed_q && ccd_armed_q &&
              !dvi_empty && !ccd_empty) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (pop) begin
            if (x_q == X_LAST) begin
              x_n = '0;
              y_n = y_q + 10'd1;
            end else begin
              x_n = x_q + 10'd1;
            end
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_SOF;
      dvi_armed_q <= 1'b0;
      ccd_armed_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      dvi_armed_q <= dvi_armed_n;
      ccd_armed_q <= ccd_armed_n;
      x_q         <= x_n;
      y_q         <= y_n;
    end
  end

  sync_fifo #(
    .W     (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_dvi_fifo (
    .clk   (clk_25),
    .rst_n (reset),
    .push  (dvi_push),
    .pop   (pop),
    .flush (flush),
    .din   (dvi_pix_i),
    .dout  (dvi_head),
    .full  (dvi_full),
    .empty (dvi_empty)
  );

  sync_fifo #(
    .W     (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_ccd_fifo (
    .clk   (clk_25),
    .rst_n (reset),
    .push  (ccd_push),
    .pop   (pop),
    .flush (flush),
    .din   (ccd_pix_i),
    .dout  (ccd_head),
    .full  (ccd_full),
    .empty (ccd_empty)
  );

  assign dvi_rgb = unpack565(dvi_head);
  assign ccd_rgb = unpack565(ccd_head);

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      overflow_o   <= 1'b0;
      syncX_o      <= '0;
      syncY_o      <= '0;
      DVI_R_o      <= '0;
      DVI_G_o      <= '0;
      DVI_B_o      <= '0;
      CCD_R_o      <= '0;
      CCD_G_o      <= '0;
      CCD_B_o      <= '0;
    end else begin
      valid_o      <= pop;
      frame_done_o <= frame_end;
      overflow_o   <= overflow_o || ovf_evt;
      if (pop) begin
        syncX_o <= x_q;
        syncY_o <= y_q;
        DVI_R_o <= dvi_rgb.r;
        DVI_G_o <= dvi_rgb.g;
        DVI_B_o <= dvi_rgb.b;
        CCD_R_o <= ccd_rgb.r;
        CCD_G_o <= ccd_rgb.g;
        CCD_B_o <= ccd_rgb.b;
      end
    end
  end

endmodule

// File: tb/tb_pix_pair_streamer.sv
// Randomized scenario bench for the DVI/CCD pair streamer on a
// reduced 8x4 frame.
module tb_pix_pair_streamer;
  import pix_pair_streamer_pkg::*;

  localparam int H = 8;
  localparam int V = 4;
  localparam int D = 16;
  localparam int N = H * V;

  logic        clk_25;
  logic        reset;
  logic        dvi_valid_i;
  logic        dvi_sof_i;
  logic [15:0] dvi_pix_i;
  logic        ccd_valid_i;
  logic        ccd_sof_i;
  logic [15:0] ccd_pix_i;
  logic        valid_o;
  logic [9:0]  syncX_o;
  logic [9:0]  syncY_o;
  logic [4:0]  DVI_R_o;
  logic [5:0]  DVI_G_o;
  logic [4:0]  DVI_B_o;
  logic [4:0]  CCD_R_o;
  logic [5:0]  CCD_G_o;
  logic [4:0]  CCD_B_o;
  logic        frame_done_o;
  logic        overflow_o;

  pix_pair_streamer #(
    .H_ACT      (H),
    .V_ACT      (V),
    .FIFO_DEPTH (D)
  ) dut (
    .clk_25       (clk_25),
    .reset        (reset),
    .dvi_valid_i  (dvi_valid_i),
    .dvi_sof_i    (dvi_sof_i),
    .dvi_pix_i    (dvi_pix_i),
    .ccd_valid_i  (ccd_valid_i),
    .ccd_sof_i    (ccd_sof_i),
    .ccd_pix_i    (ccd_pix_i),
    .valid_o      (valid_o),
    .syncX_o      (syncX_o),
    .syncY_o      (syncY_o),
    .DVI_R_o      (DVI_R_o),
    .DVI_G_o      (DVI_G_o),
    .DVI_B_o      (DVI_B_o),
    .CCD_R_o      (CCD_R_o),
    .CCD_G_o      (CCD_G_o),
    .CCD_B_o      (CCD_B_o),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o)
  );

  initial clk_25 = 1'b0;
  always #5 clk_25 = ~clk_25;

  int checks;
  int errors;
  int cyc;

  logic [15:0] o_d[$];
  logic [15:0] o_c[$];
  int          o_x[$];
  int          o_y[$];
  int          o_i[$];
  bit          o_f[$];
  logic [15:0] e_d[$];
  logic [15:0] e_c[$];
  logic [15:0] n_d[$];
  logic [15:0] n_c[$];

  function automatic logic [15:0] rpix();
    return 16'($urandom);
  endfunction

  task automatic clear_capture();
    o_d.delete(); o_c.delete(); o_x.delete();
    o_y.delete(); o_i.delete(); o_f.delete();
    e_d.delete(); e_c.delete(); n_d.delete(); n_c.delete();
    cyc = 0;
  endtask

  task automatic step(input logic dv, input logic ds, input logic [15:0] dp,
                      input logic cv, input logic cs, input logic [15:0] cp);
    dvi_valid_i = dv; dvi_sof_i = ds; dvi_pix_i = dp;
    ccd_valid_i = cv; ccd_sof_i = cs; ccd_pix_i = cp;
    @(posedge clk_25);
    #1;
    if (valid_o) begin
      o_d.push_back({DVI_R_o, DVI_G_o, DVI_B_o});
      o_c.push_back({CCD_R_o, CCD_G_o, CCD_B_o});
      o_x.push_back(int'(syncX_o));
      o_y.push_back(int'(syncY_o));
      o_f.push_back(frame_done_o);
      o_i.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 0, 16'h0);
  endtask

  task automatic do_reset();
    dvi_valid_i = 0; dvi_sof_i = 0; dvi_pix_i = 0;
    ccd_valid_i = 0; ccd_sof_i = 0; ccd_pix_i = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk_25);
    #1;
    reset = 1'b1;
    clear_capture();
  endtask

  task automatic test_reset();
    dvi_valid_i = 0; dvi_sof_i = 0; dvi_pix_i = 0;
    ccd_valid_i = 0; ccd_sof_i = 0; ccd_pix_i = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk_25);
    #1;
    checks++;
    if (valid_o !== 1'b0 || frame_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got valid=%b fd=%b want 0 0", valid_o, frame_done_o);
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow got %b want 0", overflow_o);
    end
    checks++;
    if (syncX_o !== 10'd0 || syncY_o !== 10'd0) begin
      errors++;
      $display("FAIL reset_sync got %0d,%0d want 0,0", syncX_o, syncY_o);
    end
    checks++;
    if ({DVI_R_o, DVI_G_o, DVI_B_o, CCD_R_o, CCD_G_o, CCD_B_o} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0",
               {DVI_R_o, DVI_G_o, DVI_B_o, CCD_R_o, CCD_G_o, CCD_B_o});
    end
    checks++;
    if (dut.state_q !== WAIT_SOF) begin
      errors++;
      $display("FAIL reset_state got %0d want WAIT_SOF", dut.state_q);
    end
    reset = 1'b1;
  endtask

  task automatic test_aligned();
    do_reset();
    for (int i = 0; i < N; i++) begin
      e_d.push_back(rpix());
      e_c.push_back(rpix());
    end
    for (int i = 0; i < N; i++) step(1, i == 0, e_d[i], 1, i == 0, e_c[i]);
    idle(8);
    checks++;
    if (o_d.size() != N) begin
      errors++;
      $display("FAIL aligned_count got %0d want %0d", o_d.size(), N);
    end
    if (o_i.size() > 0) begin
      checks++;
      if (o_i[0] != 2) begin
        errors++;
        $display("FAIL aligned_latency got cycle %0d want 2", o_i[0]);
      end
    end
    for (int k = 0; k < o_d.size() && k < N; k++) begin
      checks++;
      if (o_x[k] != k % H || o_y[k] != k / H || o_d[k] !== e_d[k] ||
          o_c[k] !== e_c[k] || o_f[k] != (k == N - 1)) begin
        errors++;
        $display("FAIL aligned_pair k=%0d got (%0d,%0d) d=%h c=%h fd=%0b want (%0d,%0d) d=%h c=%h fd=%0b",
                 k, o_x[k], o_y[k], o_d[k], o_c[k], o_f[k],
                 k % H, k / H, e_d[k], e_c[k], k == N - 1);
      end
    end
    checks++;
    if (valid_o !== 1'b0 || syncX_o != 10'(H - 1) || syncY_o != 10'(V - 1) ||
        {DVI_R_o, DVI_G_o, DVI_B_o} !== e_d[N-1] ||
        {CCD_R_o, CCD_G_o, CCD_B_o} !== e_c[N-1]) begin
      errors++;
      $display("FAIL aligned_hold got v=%b (%0d,%0d) d=%h c=%h want v=0 (%0d,%0d) d=%h c=%h",
               valid_o, syncX_o, syncY_o, {DVI_R_o, DVI_G_o, DVI_B_o},
               {CCD_R_o, CCD_G_o, CCD_B_o}, H - 1, V - 1, e_d[N-1], e_c[N-1]);
    end
  endtask

  task automatic test_lag();
    do_reset();
    for (int i = 0; i < N; i++) begin
      e_d.push_back(rpix());
      e_c.push_back(rpix());
    end
    for (int i = 0; i < N + 5; i++) begin
      step(i < N, i == 0, (i < N) ? e_d[i] : 16'h0,
           i >= 5, i == 5, (i >= 5) ? e_c[i-5] : 16'h0);
    end
    idle(8);
    checks++;
    if (o_d.size() != N) begin
      errors++;
      $display("FAIL lag_count got %0d want %0d", o_d.size(), N);
    end
    if (o_i.size() > 0) begin
      checks++;
      if (o_i[0] != 7) begin
        errors++;
        $display("FAIL lag_first got cycle %0d want 7 (after ccd sof at 5)", o_i[0]);
      end
    end
    for (int k = 0; k < o_d.size() && k < N; k++) begin
      checks++;
      if (o_i[k] != 7 + k || o_x[k] != k % H || o_y[k] != k / H ||
          o_d[k] !== e_d[k] || o_c[k] !== e_c[k] || o_f[k] != (k == N - 1)) begin
        errors++;
        $display("FAIL lag_pair k=%0d got cyc=%0d (%0d,%0d) d=%h c=%h want cyc=%0d (%0d,%0d) d=%h c=%h",
                 k, o_i[k], o_x[k], o_y[k], o_d[k], o_c[k],
                 7 + k, k % H, k / H, e_d[k], e_c[k]);
      end
    end
  endtask

  task automatic test_pre_sof();
    logic [15:0] first;
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 16'hFFFF, 1, 0, rpix());
    e_d.push_back(16'h0841);
    e_c.push_back(rpix());
    for (int i = 1; i < 4; i++) begin
      e_d.push_back(rpix());
      e_c.push_back(rpix());
    end
    for (int i = 0; i < 4; i++) step(1, i == 0, e_d[i], 1, i == 0, e_c[i]);
    idle(6);
    checks++;
    if (o_d.size() != 4) begin
      errors++;
      $display("FAIL presof_count got %0d want 4", o_d.size());
    end
    if (o_d.size() > 0) begin
      first = o_d[0];
      checks++;
      if (first[15:11] != 5'd1 || first[10:5] != 6'd2 || first[4:0] != 5'd1) begin
        errors++;
        $display("FAIL presof_rgb got R=%0d G=%0d B=%0d want R=1 G=2 B=1",
                 first[15:11], first[10:5], first[4:0]);
      end
      checks++;
      if (o_i[0] != 12 || o_c[0] !== e_c[0] || o_x[0] != 0 || o_y[0] != 0) begin
        errors++;
        $display("FAIL presof_first got cyc=%0d c=%h (%0d,%0d) want cyc=12 c=%h (0,0)",
                 o_i[0], o_c[0], o_x[0], o_y[0], e_c[0]);
      end
    end
  endtask

  task automatic test_overflow();
    int ovf_at;
    ovf_at = -1;
    do_reset();
    e_d.push_back(rpix());
    e_c.push_back(rpix());
    for (int i = 0; i < 21; i++) begin
      step(1, i == 0, (i == 0) ? e_d[0] : rpix(), i == 0, i == 0, e_c[0]);
      if (overflow_o === 1'b1 && ovf_at < 0) ovf_at = cyc - 1;
    end
    checks++;
    if (ovf_at != D + 1) begin
      errors++;
      $display("FAIL ovf_onset got cycle %0d want %0d", ovf_at, D + 1);
    end
    checks++;
    if (dut.state_q !== WAIT_SOF) begin
      errors++;
      $display("FAIL ovf_state got %0d want WAIT_SOF", dut.state_q);
    end
    for (int i = 0; i < 6; i++) step(1, 0, rpix(), 1, 0, rpix());
    checks++;
    if (o_d.size() != 1 || o_d[0] !== e_d[0] || o_c[0] !== e_c[0]) begin
      errors++;
      $display("FAIL ovf_quiet got %0d outputs want 1 (pre-stall pair)", o_d.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_d.push_back(rpix());
      n_c.push_back(rpix());
    end
    for (int i = 0; i < 4; i++) step(1, i == 0, n_d[i], 1, i == 0, n_c[i]);
    idle(6);
    checks++;
    if (o_d.size() != 5) begin
      errors++;
      $display("FAIL ovf_resume_count got %0d want 5", o_d.size());
    end
    for (int k = 1; k < o_d.size() && k < 5; k++) begin
      checks++;
      if (o_i[k] != 28 + k || o_x[k] != k - 1 || o_y[k] != 0 ||
          o_d[k] !== n_d[k-1] || o_c[k] !== n_c[k-1]) begin
        errors++;
        $display("FAIL ovf_resume k=%0d got cyc=%0d (%0d,%0d) d=%h c=%h want cyc=%0d (%0d,0) d=%h c=%h",
                 k, o_i[k], o_x[k], o_y[k], o_d[k], o_c[k],
                 28 + k, k - 1, n_d[k-1], n_c[k-1]);
      end
    end
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b want 1", overflow_o);
    end
  endtask

  task automatic test_resync();
    int r;
    int m;
    int n_old;
    int n_new;
    r = 2 * H + 5;
    m = 12;
    n_old = 0;
    n_new = 0;
    do_reset();
    for (int i = 0; i < r + 5; i++) begin
      e_d.push_back(rpix());
      e_c.push_back(rpix());
    end
    for (int i = 0; i < m; i++) begin
      n_d.push_back(rpix());
      n_c.push_back(rpix());
    end
    for (int i = 0; i < r + 5 + m; i++) begin
      logic        dv;
      logic        cv;
      logic [15:0] dp;
      logic [15:0] cp;
      dv = (i < r + m);
      dp = (i < r) ? e_d[i] : (i < r + m) ? n_d[i-r] : 16'h0;
      cv = 1'b1;
      cp = (i < r + 5) ? e_c[i] : n_c[i-r-5];
      step(dv, i == 0 || i == r, dp, cv, i == 0 || i == r + 5, cp);
    end
    idle(10);
    for (int k = 0; k < o_d.size(); k++) begin
      if (o_i[k] <= r) begin
        checks++;
        if (o_x[k] != n_old % H || o_y[k] != n_old / H ||
            o_d[k] !== e_d[n_old] || o_c[k] !== e_c[n_old]) begin
          errors++;
          $display("FAIL resync_old k=%0d got (%0d,%0d) d=%h c=%h want (%0d,%0d) d=%h c=%h",
                   n_old, o_x[k], o_y[k], o_d[k], o_c[k],
                   n_old % H, n_old / H, e_d[n_old], e_c[n_old]);
        end
        n_old++;
      end else if (n_new < m) begin
        checks++;
        if (o_i[k] != r + 7 + n_new || o_x[k] != n_new % H || o_y[k] != n_new / H ||
            o_d[k] !== n_d[n_new] || o_c[k] !== n_c[n_new]) begin
          errors++;
          $display("FAIL resync_new k=%0d got cyc=%0d (%0d,%0d) d=%h c=%h want cyc=%0d (%0d,%0d) d=%h c=%h",
                   n_new, o_i[k], o_x[k], o_y[k], o_d[k], o_c[k],
                   r + 7 + n_new, n_new % H, n_new / H, n_d[n_new], n_c[n_new]);
        end
        n_new++;
      end
    end
    checks++;
    if (n_old != r - 1 || o_d.size() != r - 1 + m) begin
      errors++;
      $display("FAIL resync_count got old=%0d total=%0d want old=%0d total=%0d",
               n_old, o_d.size(), r - 1, r - 1 + m);
    end
  endtask

  task automatic test_reset_mid();
    int p;
    p = N / 2 + H / 2;
    do_reset();
    for (int i = 0; i < p; i++) begin
      e_d.push_back(rpix());
      e_c.push_back(rpix());
    end
    for (int i = 0; i < p; i++) step(1, i == 0, e_d[i], 1, i == 0, e_c[i]);
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_streaming got valid=%b want 1", valid_o);
    end
    @(negedge clk_25);
    reset = 1'b0;
    dvi_valid_i = 0; ccd_valid_i = 0; dvi_sof_i = 0; ccd_sof_i = 0;
    #1;
    checks++;
    if ({valid_o, frame_done_o, overflow_o, syncX_o, syncY_o} !== 23'h0 ||
        {DVI_R_o, DVI_G_o, DVI_B_o, CCD_R_o, CCD_G_o, CCD_B_o} !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b fd=%b ov=%b (%0d,%0d) data=%h want all 0",
               valid_o, frame_done_o, overflow_o, syncX_o, syncY_o,
               {DVI_R_o, DVI_G_o, DVI_B_o, CCD_R_o, CCD_G_o, CCD_B_o});
    end
    @(posedge clk_25);
    #1;
    reset = 1'b1;
    clear_capture();
    for (int i = 0; i < 5; i++) step(1, 0, rpix(), 1, 0, rpix());
    for (int i = 0; i < 6; i++) begin
      n_d.push_back(rpix());
      n_c.push_back(rpix());
    end
    for (int i = 0; i < 6; i++) step(1, i == 0, n_d[i], 1, i == 0, n_c[i]);
    idle(6);
    checks++;
    if (o_d.size() != 6) begin
      errors++;
      $display("FAIL midreset_count got %0d want 6", o_d.size());
    end
    for (int k = 0; k < o_d.size() && k < 6; k++) begin
      checks++;
      if (o_i[k] != 7 + k || o_x[k] != k || o_y[k] != 0 ||
          o_d[k] !== n_d[k] || o_c[k] !== n_c[k]) begin
        errors++;
        $display("FAIL midreset_pair k=%0d got cyc=%0d (%0d,%0d) d=%h c=%h want cyc=%0d (%0d,0) d=%h c=%h",
                 k, o_i[k], o_x[k], o_y[k], o_d[k], o_c[k], 7 + k, k, n_d[k], n_c[k]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_aligned();
    test_lag();
    test_pre_sof();
    test_overflow();
    test_resync();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
